rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one resource between 8 requesters.
- Issues a registered 3-bit grant index. That index is expanded through a one-hot 3-to-8 decode into per-requester grant strobes.
- Enforces a bounded hold time so no requester can starve the others.
- Sits in front of any shared 8-way-selected datapath (bus slot, mux select, bank enable).

---
 rtl/arb_pkg.sv | 32 +++
 rtl/onehot_dec_3to8.sv | 14 +
 rtl/rr_arbiter_8.sv | 117 +++++++++++
 tb/tb_rr_arbiter_8.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, constants and the round-robin pick function for the
// 8-way arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set bit of vec, scanning upward from ptr and wrapping 7->0.
  // Returns {found, idx}. idx is 0 when nothing is found.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] vec,
                                             input logic [IDX_W-1:0] ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/onehot_dec_3to8.sv
// 3-bit index to 8-bit one-hot decoder. Output is all-zero when en is low.
module onehot_dec_3to8 (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  // Set the single bit selected by idx, but only when enabled.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time.
// The owner keeps the grant while it holds its request. It is rotated out
// after MAX_HOLD consecutive cycles when other requests are present.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);
  import arb_pkg::*;

  localparam int unsigned      HC_W   = $clog2(MAX_HOLD);
  localparam logic [HC_W-1:0]  HC_MAX = HC_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;
  logic             pre_d;
  logic [N_REQ-1:0] gnt_d;

  logic [IDX_W:0]   pick_idle;  // fresh arbitration from ptr
  logic [IDX_W:0]   pick_rel;   // handover with the owner masked out
  logic [IDX_W:0]   pick_rot;   // timeout, owner at lowest priority

  // Winner candidates for each of the three arbitration situations.
  always_comb begin
    pick_idle = rr_pick(req, ptr_q);
    pick_rel  = rr_pick(req & ~gnt, ptr_q);
    pick_rot  = rr_pick(req, gnt_idx + 1'b1);
  end

  // Next-state and next-output selection.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hc_d    = hc_q;
    idx_d   = gnt_idx;
    valid_d = gnt_valid;
    pre_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_idle[IDX_W]) begin
          state_d = GRANT;
          valid_d = 1'b1;
          idx_d   = pick_idle[IDX_W-1:0];
          ptr_d   = pick_idle[IDX_W-1:0] + 1'b1;
          hc_d    = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          // A release wins over a timeout on the same edge.
          if (en && pick_rel[IDX_W]) begin
            idx_d = pick_rel[IDX_W-1:0];
            ptr_d = pick_rel[IDX_W-1:0] + 1'b1;
            hc_d  = '0;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            hc_d    = '0;
          end
        end else if (hc_q != HC_MAX) begin
          hc_d = hc_q + 1'b1;
        end else if (en) begin
          // Owner's own bit is still set, so a winner always exists.
          pre_d = 1'b1;
          idx_d = pick_rot[IDX_W-1:0];
          ptr_d = pick_rot[IDX_W-1:0] + 1'b1;
          hc_d  = '0;
        end
        // With en low at timeout the grant is kept and hc stays saturated.
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // The next index is decoded before the register so that gnt always
  // matches gnt_idx and gnt_valid on the same cycle.
  onehot_dec_3to8 u_dec (
    .en     (valid_d),
    .idx    (idx_d),
    .onehot (gnt_d)
  );

  // Arbiter state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hc_q      <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      gnt       <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hc_q      <= hc_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      preempt   <= pre_d;
      gnt       <= gnt_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scenario bench for rr_arbiter_8 (MAX_HOLD=4).
// Each scenario pushes its expected per-cycle outputs to a scoreboard and
// pops them as the DUT produces each cycle.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       p;
    logic       ci;   // compare gnt_idx too
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [7:0] g, input logic [2:0] i,
                      input logic v, input logic p);
    exp_t e;
    e.g = g; e.i = i; e.v = v; e.p = p; e.ci = v;
    sb.push_back(e);
  endtask

  task automatic push_rst();
    exp_t e;
    e = '0;
    e.ci = 1'b1;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    en    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b1;
    req   = 8'hFF;
    en    = 1'b1;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_rst();
      if (k == 0) #1; else @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL reset: scoreboard empty");
      end else begin
        e = sb.pop_front();
        if ({gnt, gnt_valid, preempt, gnt_idx} !== {e.g, e.v, e.p, e.i}) begin
          errors++;
          $display("FAIL reset %0d: got gnt=%h idx=%0d v=%b p=%b want gnt=%h idx=%0d v=%b p=%b",
                   k, gnt, gnt_idx, gnt_valid, preempt, e.g, e.i, e.v, e.p);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;
  endtask

  task automatic test_single();
    logic [7:0] r[2];
    exp_t e;
    do_reset();
    r[0] = 8'h01; push(8'h01, 3'd0, 1'b1, 1'b0);
    r[1] = 8'h00; push(8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      req = r[k]; en = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL single: scoreboard empty");
      end else begin
        e = sb.pop_front();
        if ({gnt, gnt_valid, preempt, (e.ci ? gnt_idx : 3'd0)} !== {e.g, e.v, e.p, (e.ci ? e.i : 3'd0)}) begin
          errors++;
          $display("FAIL single %0d: got gnt=%h idx=%0d v=%b p=%b want gnt=%h idx=%0d v=%b p=%b",
                   k, gnt, gnt_idx, gnt_valid, preempt, e.g, e.i, e.v, e.p);
        end
      end
    end
  endtask

  task automatic test_rotate();
    exp_t e;
    logic [2:0] o;
    do_reset();
    // Edge n (1-based) after req=FF: owner (n-1)/4 mod 8; preempt on owner change.
    for (int n = 1; n <= 33; n++) begin
      o = 3'((n - 1) / 4);
      push(8'h01 << o, o, 1'b1, (n > 1) && ((n - 1) % 4 == 0));
    end
    push(8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 34; k++) begin
      req = (k < 33) ? 8'hFF : 8'h00; en = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL rotate: scoreboard empty");
      end else begin
        e = sb.pop_front();
        if ({gnt, gnt_valid, preempt, (e.ci ? gnt_idx : 3'd0)} !== {e.g, e.v, e.p, (e.ci ? e.i : 3'd0)}) begin
          errors++;
          $display("FAIL rotate %0d: got gnt=%h idx=%0d v=%b p=%b want gnt=%h idx=%0d v=%b p=%b",
                   k, gnt, gnt_idx, gnt_valid, preempt, e.g, e.i, e.v, e.p);
        end
      end
    end
  endtask

  task automatic test_handover();
    logic [7:0] r[4];
    exp_t e;
    do_reset();
    r[0] = 8'h08; push(8'h08, 3'd3, 1'b1, 1'b0);
    r[1] = 8'h81; push(8'h80, 3'd7, 1'b1, 1'b0);
    r[2] = 8'h80; push(8'h80, 3'd7, 1'b1, 1'b0);
    r[3] = 8'h00; push(8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      req = r[k]; en = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL handover: scoreboard empty");
      end else begin
        e = sb.pop_front();
        if ({gnt, gnt_valid, preempt, (e.ci ? gnt_idx : 3'd0)} !== {e.g, e.v, e.p, (e.ci ? e.i : 3'd0)}) begin
          errors++;
          $display("FAIL handover %0d: got gnt=%h idx=%0d v=%b p=%b want gnt=%h idx=%0d v=%b p=%b",
                   k, gnt, gnt_idx, gnt_valid, preempt, e.g, e.i, e.v, e.p);
        end
      end
    end
  endtask

  task automatic test_lone();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 10; n++) push(8'h20, 3'd5, 1'b1, (n == 5) || (n == 9));
    push(8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) begin
      req = (k < 10) ? 8'h20 : 8'h00; en = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL lone: scoreboard empty");
      end else begin
        e = sb.pop_front();
        if ({gnt, gnt_valid, preempt, (e.ci ? gnt_idx : 3'd0)} !== {e.g, e.v, e.p, (e.ci ? e.i : 3'd0)}) begin
          errors++;
          $display("FAIL lone %0d: got gnt=%h idx=%0d v=%b p=%b want gnt=%h idx=%0d v=%b p=%b",
                   k, gnt, gnt_idx, gnt_valid, preempt, e.g, e.i, e.v, e.p);
        end
      end
    end
  endtask

  task automatic test_en_hold();
    logic [7:0] r[14];
    logic       en_v[14];
    exp_t e;
    do_reset();
    r[0] = 8'h04; en_v[0] = 1'b1; push(8'h04, 3'd2, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      r[k] = 8'h06; en_v[k] = 1'b0; push(8'h04, 3'd2, 1'b1, 1'b0);
    end
    for (int k = 8; k <= 11; k++) begin
      r[k] = 8'h02; en_v[k] = 1'b0; push(8'h00, 3'd0, 1'b0, 1'b0);
    end
    r[12] = 8'h02; en_v[12] = 1'b1; push(8'h02, 3'd1, 1'b1, 1'b0);
    r[13] = 8'h00; en_v[13] = 1'b1; push(8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      req = r[k]; en = en_v[k];
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL en_hold: scoreboard empty");
      end else begin
        e = sb.pop_front();
        if ({gnt, gnt_valid, preempt, (e.ci ? gnt_idx : 3'd0)} !== {e.g, e.v, e.p, (e.ci ? e.i : 3'd0)}) begin
          errors++;
          $display("FAIL en_hold %0d: got gnt=%h idx=%0d v=%b p=%b want gnt=%h idx=%0d v=%b p=%b",
                   k, gnt, gnt_idx, gnt_valid, preempt, e.g, e.i, e.v, e.p);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin
        // Assert reset mid-cycle and look again before any clock edge.
        rst_n = 1'b0;
        push_rst();
        #1;
      end else begin
        if (k == 4) begin
          @(negedge clk);
          rst_n = 1'b1;
        end
        if (k < 6) begin
          push(8'h01, 3'd0, 1'b1, 1'b0);
          req = 8'hFF;
        end else begin
          push(8'h00, 3'd0, 1'b0, 1'b0);
          req = 8'h00;
        end
        en = 1'b1;
        @(posedge clk); #1;
      end
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL reset_mid: scoreboard empty");
      end else begin
        e = sb.pop_front();
        if ({gnt, gnt_valid, preempt, (e.ci ? gnt_idx : 3'd0)} !== {e.g, e.v, e.p, (e.ci ? e.i : 3'd0)}) begin
          errors++;
          $display("FAIL reset_mid %0d: got gnt=%h idx=%0d v=%b p=%b want gnt=%h idx=%0d v=%b p=%b",
                   k, gnt, gnt_idx, gnt_valid, preempt, e.g, e.i, e.v, e.p);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    req   = '0;
    test_reset();
    test_single();
    test_rotate();
    test_handover();
    test_lone();
    test_en_hold();
    test_reset_mid();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d scoreboard entries remain, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the run cannot hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
